// File: rtl/vjtag_bridge_pkg.sv
// Shared types and header-field helpers for the virtual-JTAG register bridge.
package vjtag_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_DATA = 2'd1,
        GET_CSUM = 2'd2
    } state_t;

    localparam logic OP_WRITE = 1'b1;
    localparam logic OP_READ  = 1'b0;

    localparam int HDR_OP_BIT  = 7;
    localparam int HDR_RSV_MSB = 6;

    function automatic int addr_w(input int nregs);
        return $clog2(nregs);
    endfunction

    // Reserved bits are everything between the op bit and the address field.
    function automatic logic [7:0] rsv_mask(input int nregs);
        logic [7:0] body;
        body = '0;
        for (int i = 0; i <= HDR_RSV_MSB; i++) begin
            body[i] = 1'b1;
        end
        return body & ~8'(nregs - 1);
    endfunction

endpackage

// File: rtl/vjtag_reg_bank.sv
// NREGS x 8 register file: one write port, combinational read mux, flattened view.
module vjtag_reg_bank
    import vjtag_bridge_pkg::*;
#(
    parameter int         NREGS     = 8,
    parameter logic [7:0] RESET_VAL = 8'h00,
    localparam int        AW        = addr_w(NREGS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic [7:0]           i_wdata,
    input  logic [AW-1:0]        i_raddr,
    output logic [7:0]           o_rdata,
    output logic [8*NREGS-1:0]   o_flat
);

    logic [7:0] r_regs [NREGS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_regs[i_raddr];

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign o_flat[8*g +: 8] = r_regs[g];
    end

endmodule

// File: rtl/vjtag_reg_bridge.sv
// Decodes framed read/write commands from the virtual-JTAG DR shifter into a
// small register bank, with a saturating rejected-frame counter at the top address.
module vjtag_reg_bridge
    import vjtag_bridge_pkg::*;
#(
    parameter int         NREGS     = 8,
    parameter logic [7:0] RESET_VAL = 8'h00,
    parameter logic [7:0] ERR_SAT   = 8'hFF
) (
    input  logic                 tck,
    input  logic                 aclr,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_valid,
    input  logic                 abort,
    output logic [7:0]           tx_byte,
    output logic                 tx_valid,
    output logic [8*NREGS-1:0]   regs_flat,
    output logic                 wr_strobe,
    output logic [2:0]           wr_addr,
    output logic [7:0]           err_cnt,
    output logic                 busy
);

    localparam int            AW          = addr_w(NREGS);
    localparam logic [AW-1:0] STATUS_ADDR = AW'(NREGS - 1);
    localparam logic [7:0]    RSV_MASK    = rsv_mask(NREGS);

    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_hdr;
    logic [7:0]    r_data;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_tx_byte;
    logic          r_tx_valid;
    logic          r_wr_strobe;
    logic [2:0]    r_wr_addr;
    logic [7:0]    r_err_cnt;

    logic          w_accept;
    logic          w_hdr_rsv;
    logic          w_hdr_op;
    logic [AW-1:0] w_hdr_addr;
    logic          w_csum_ok;
    logic          w_rd_req;
    logic          w_latch_hdr;
    logic          w_latch_data;
    logic          w_commit;
    logic          w_err_inc;
    logic          w_bank_we;
    logic [7:0]    w_bank_rdata;
    logic [7:0]    w_rd_data;

    assign w_accept   = rx_valid & ~abort;
    assign w_hdr_rsv  = |(rx_byte & RSV_MASK);
    assign w_hdr_op   = rx_byte[HDR_OP_BIT];
    assign w_hdr_addr = rx_byte[AW-1:0];
    assign w_csum_ok  = (rx_byte == (r_hdr ^ r_data));

    always_ff @(posedge tck or posedge aclr) begin
        if (aclr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Abort beats a coincident byte, so it is tested before rx_valid.
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = IDLE;
        end else if (rx_valid) begin
            case (r_state)
                IDLE:     if (!w_hdr_rsv && w_hdr_op == OP_WRITE) w_next_state = GET_DATA;
                GET_DATA: w_next_state = GET_CSUM;
                GET_CSUM: w_next_state = IDLE;
                default:  w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd_req     = 1'b0;
        w_latch_hdr  = 1'b0;
        w_latch_data = 1'b0;
        w_commit     = 1'b0;
        w_err_inc    = 1'b0;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (w_hdr_rsv)                 w_err_inc   = 1'b1;
                    else if (w_hdr_op == OP_READ)  w_rd_req    = 1'b1;
                    else                           w_latch_hdr = 1'b1;
                end
                GET_DATA: w_latch_data = 1'b1;
                GET_CSUM: begin
                    if (w_csum_ok) w_commit  = 1'b1;
                    else           w_err_inc = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);

    // The status address is not backed by the bank; writing it only clears err_cnt.
    assign w_bank_we = w_commit && (r_addr != STATUS_ADDR);
    assign w_rd_data = (w_hdr_addr == STATUS_ADDR) ? r_err_cnt : w_bank_rdata;

    always_ff @(posedge tck or posedge aclr) begin
        if (aclr) begin
            r_hdr       <= '0;
            r_data      <= '0;
            r_addr      <= '0;
            r_tx_byte   <= '0;
            r_tx_valid  <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_tx_valid  <= w_rd_req;
            r_wr_strobe <= w_commit;
            if (w_latch_hdr) begin
                r_hdr  <= rx_byte;
                r_addr <= w_hdr_addr;
            end
            if (w_latch_data) begin
                r_data <= rx_byte;
            end
            if (w_rd_req) begin
                r_tx_byte <= w_rd_data;
            end
            if (w_commit) begin
                r_wr_addr <= 3'(r_addr);
            end
            if (w_commit && r_addr == STATUS_ADDR) begin
                r_err_cnt <= '0;
            end else if (w_err_inc && r_err_cnt != ERR_SAT) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    vjtag_reg_bank #(
        .NREGS     (NREGS),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .i_clk   (tck),
        .i_rst   (aclr),
        .i_we    (w_bank_we),
        .i_waddr (r_addr),
        .i_wdata (r_data),
        .i_raddr (w_hdr_addr),
        .o_rdata (w_bank_rdata),
        .o_flat  (regs_flat)
    );

    assign tx_byte   = r_tx_byte;
    assign tx_valid  = r_tx_valid;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_vjtag_reg_bridge.sv
// Bench for vjtag_reg_bridge: directed vector table, hand sequences for reset,
// saturation, then random frames checked against a frame-level queue model.
module tb_vjtag_reg_bridge;

    logic        tck = 1'b0;
    logic        aclr;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        abort;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic [63:0] regs_flat;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic [7:0]  err_cnt;
    logic        busy;

    int nChecks = 0;
    int nErrors = 0;

    vjtag_reg_bridge dut (
        .tck       (tck),
        .aclr      (aclr),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .abort     (abort),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #5 tck = ~tck;

    typedef struct {
        logic        rv;
        logic [7:0]  rb;
        logic        ab;
        logic        txv;
        logic [7:0]  txb;
        logic        ws;
        logic [2:0]  wa;
        logic [7:0]  err;
        logic        bsy;
        logic [63:0] regs;
    } vec_t;

    vec_t tbl[$];

    // Frame-level reference: a byte queue holds the partial frame.
    logic [7:0] mRegs [8];
    logic [7:0] mErr;
    logic [7:0] mTx;
    logic       mTxv;
    logic       mWs;
    logic [2:0] mWa;
    logic [7:0] mFrame[$];

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    function automatic logic [63:0] modelFlat();
        logic [63:0] f;
        for (int i = 0; i < 8; i++) f[8*i +: 8] = mRegs[i];
        return f;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mRegs[i] = 8'h00;
        mErr = 0; mTx = 0; mTxv = 0; mWs = 0; mWa = 0;
        mFrame.delete();
    endtask

    task automatic modelStep(input logic rv, input logic [7:0] rb, input logic ab);
        logic [2:0] a;
        mTxv = 1'b0;
        mWs  = 1'b0;
        if (ab) begin
            mFrame.delete();
        end else if (rv) begin
            if (mFrame.size() == 0) begin
                a = rb[2:0];
                if ((rb & 8'h78) != 0) mErr = satInc(mErr);
                else if (!rb[7]) begin
                    mTxv = 1'b1;
                    mTx  = (a == 3'd7) ? mErr : mRegs[a];
                end else mFrame.push_back(rb);
            end else if (mFrame.size() == 1) begin
                mFrame.push_back(rb);
            end else begin
                a = mFrame[0][2:0];
                if (rb == (mFrame[0] ^ mFrame[1])) begin
                    if (a == 3'd7) mErr = 8'h00;
                    else mRegs[a] = mFrame[1];
                    mWs = 1'b1;
                    mWa = a;
                end else mErr = satInc(mErr);
                mFrame.delete();
            end
        end
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic txv, input logic [7:0] txb,
                               input logic ws, input logic [2:0] wa, input logic [7:0] err,
                               input logic bsy, input logic [63:0] regs);
        cmp({tag, ".tx_valid"},  64'(tx_valid),  64'(txv));
        cmp({tag, ".tx_byte"},   64'(tx_byte),   64'(txb));
        cmp({tag, ".wr_strobe"}, 64'(wr_strobe), 64'(ws));
        cmp({tag, ".wr_addr"},   64'(wr_addr),   64'(wa));
        cmp({tag, ".err_cnt"},   64'(err_cnt),   64'(err));
        cmp({tag, ".busy"},      64'(busy),      64'(bsy));
        cmp({tag, ".regs_flat"}, regs_flat,      regs);
    endtask

    // Called at a falling edge; the byte is sampled on the following rising edge.
    task automatic applyStimulus(input logic rv, input logic [7:0] rb, input logic ab);
        rx_valid = rv;
        rx_byte  = rb;
        abort    = ab;
        @(posedge tck);
        modelStep(rv, rb, ab);
        @(negedge tck);
        rx_valid = 1'b0;
        abort    = 1'b0;
    endtask

    function automatic vec_t mk(input logic rv, input logic [7:0] rb, input logic ab,
                                input logic txv, input logic [7:0] txb, input logic ws,
                                input logic [2:0] wa, input logic [7:0] err, input logic bsy,
                                input logic [63:0] regs);
        vec_t v;
        v.rv = rv; v.rb = rb; v.ab = ab; v.txv = txv; v.txb = txb; v.ws = ws;
        v.wa = wa; v.err = err; v.bsy = bsy; v.regs = regs;
        return v;
    endfunction

    initial begin
        logic       rv;
        logic       ab;
        logic [7:0] rb;

        aclr = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; abort = 1'b0;
        modelReset();
        repeat (2) @(negedge tck);
        checkOutput("reset", 0, 8'h00, 0, 0, 8'h00, 0, 64'h0);
        aclr = 1'b0;
        @(negedge tck);

        //        rv  byte   ab txv txb    ws wa err    bsy regs
        tbl.push_back(mk(1, 8'h80, 0, 0, 8'h00, 0, 0, 8'h00, 1, 64'h0));
        tbl.push_back(mk(1, 8'hA5, 0, 0, 8'h00, 0, 0, 8'h00, 1, 64'h0));
        tbl.push_back(mk(1, 8'h25, 0, 0, 8'h00, 1, 0, 8'h00, 0, 64'hA5));
        tbl.push_back(mk(1, 8'h00, 0, 1, 8'hA5, 0, 0, 8'h00, 0, 64'hA5));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'hA5, 0, 0, 8'h00, 0, 64'hA5));
        tbl.push_back(mk(1, 8'h83, 0, 0, 8'hA5, 0, 0, 8'h00, 1, 64'hA5));
        tbl.push_back(mk(1, 8'h11, 0, 0, 8'hA5, 0, 0, 8'h00, 1, 64'hA5));
        tbl.push_back(mk(1, 8'h00, 0, 0, 8'hA5, 0, 0, 8'h01, 0, 64'hA5));
        tbl.push_back(mk(1, 8'h03, 0, 1, 8'h00, 0, 0, 8'h01, 0, 64'hA5));
        tbl.push_back(mk(1, 8'h48, 0, 0, 8'h00, 0, 0, 8'h02, 0, 64'hA5));
        tbl.push_back(mk(1, 8'h07, 0, 1, 8'h02, 0, 0, 8'h02, 0, 64'hA5));
        tbl.push_back(mk(1, 8'h87, 0, 0, 8'h02, 0, 0, 8'h02, 1, 64'hA5));
        tbl.push_back(mk(1, 8'h00, 0, 0, 8'h02, 0, 0, 8'h02, 1, 64'hA5));
        tbl.push_back(mk(1, 8'h87, 0, 0, 8'h02, 1, 7, 8'h00, 0, 64'hA5));
        tbl.push_back(mk(1, 8'h81, 0, 0, 8'h02, 0, 7, 8'h00, 1, 64'hA5));
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h02, 0, 7, 8'h00, 0, 64'hA5));
        tbl.push_back(mk(1, 8'h81, 0, 0, 8'h02, 0, 7, 8'h00, 1, 64'hA5));
        tbl.push_back(mk(1, 8'h5A, 0, 0, 8'h02, 0, 7, 8'h00, 1, 64'hA5));
        tbl.push_back(mk(1, 8'hDB, 0, 0, 8'h02, 1, 1, 8'h00, 0, 64'h5AA5));
        tbl.push_back(mk(1, 8'h82, 0, 0, 8'h02, 0, 1, 8'h00, 1, 64'h5AA5));
        tbl.push_back(mk(1, 8'h3C, 1, 0, 8'h02, 0, 1, 8'h00, 0, 64'h5AA5));
        tbl.push_back(mk(1, 8'h82, 0, 0, 8'h02, 0, 1, 8'h00, 1, 64'h5AA5));
        tbl.push_back(mk(1, 8'h3C, 0, 0, 8'h02, 0, 1, 8'h00, 1, 64'h5AA5));
        tbl.push_back(mk(1, 8'hBE, 0, 0, 8'h02, 1, 2, 8'h00, 0, 64'h3C5AA5));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].rv, tbl[i].rb, tbl[i].ab);
            checkOutput($sformatf("vec%0d", i), tbl[i].txv, tbl[i].txb, tbl[i].ws,
                        tbl[i].wa, tbl[i].err, tbl[i].bsy, tbl[i].regs);
        end

        // Clear lands mid-frame, after a rejected header has bumped err_cnt.
        applyStimulus(1, 8'h48, 0);
        applyStimulus(1, 8'h81, 0);
        aclr = 1'b1;
        #1;
        checkOutput("midreset", 0, 8'h00, 0, 0, 8'h00, 0, 64'h0);
        modelReset();
        @(negedge tck);
        aclr = 1'b0;
        @(negedge tck);
        applyStimulus(1, 8'h82, 0);
        applyStimulus(1, 8'h3C, 0);
        applyStimulus(1, 8'hBE, 0);
        checkOutput("postreset", 0, 8'h00, 1, 2, 8'h00, 0, 64'h3C0000);

        for (int i = 0; i < 300; i++) begin
            rb = 8'($urandom) | 8'h40;
            applyStimulus(1, rb, 0);
            cmp("sat.busy", 64'(busy), 64'(0));
            cmp("sat.tx_valid", 64'(tx_valid), 64'(0));
        end
        cmp("sat.err_cnt", 64'(err_cnt), 64'hFF);

        for (int i = 0; i < 600; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            ab = ($urandom_range(0, 19) == 0);
            case (mFrame.size())
                0: begin
                    if ($urandom_range(0, 9) == 0) rb = 8'($urandom) | 8'h08;
                    else rb = {1'($urandom), 4'b0000, 3'($urandom)};
                end
                1: rb = 8'($urandom);
                default: begin
                    if ($urandom_range(0, 3) != 0) rb = mFrame[0] ^ mFrame[1];
                    else rb = 8'($urandom);
                end
            endcase
            applyStimulus(rv, rb, ab);
            checkOutput("rand", mTxv, mTx, mWs, mWa, mErr, mFrame.size() != 0, modelFlat());
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/vjtag_reg_bridge.md
Name: vjtag_reg_bridge

Overview:
- Sits directly downstream of the virtual-JTAG DR shifter, in the TCK domain.
- Consumes the byte stream that the shifter delivers on each DR update.
- Decodes a framed read/write command protocol into a small register bank; register 0 drives the board LEDs.
- Returns read data to the shifter, which loads it on the next DR capture.

Parameters:
- NREGS, 8, number of 8-bit registers; power of two, 2..8. Address field is clog2(NREGS) bits.
- RESET_VAL, 8'h00, reset value of every writable register.
- ERR_SAT, 8'hFF, saturation value of the error counter.

Ports:
- tck  input  1  virtual-JTAG TCK; the only clock.
- aclr  input  1  asynchronous clear, active-high.
- rx_byte  input  8  byte delivered by the DR shifter.
- rx_valid  input  1  one-tck pulse: rx_byte is valid (issued on DR update).
- abort  input  1  one-tck pulse on IR update; discards any partial frame.
- tx_byte  output  8  read-response byte for the shifter to capture.
- tx_valid  output  1  one-tck pulse: tx_byte is updated.
- regs_flat  output  8*NREGS  all registers; reg i is at bits [8i+7:8i].
- wr_strobe  output  1  one-tck pulse after a register commit.
- wr_addr  output  3  address of the last commit.
- err_cnt  output  8  saturating count of rejected frames.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset is asynchronous on aclr. While aclr is high:
  - state = IDLE;
  - every register = RESET_VAL;
  - tx_byte = 0, tx_valid = 0, wr_strobe = 0, wr_addr = 0, err_cnt = 0, busy = 0.
- Reset asserted mid-frame discards the frame.
- Header byte fields:
  - bit7 = op: 1 = write, 0 = read.
  - bits[6:A] are reserved and must be 0, where A = clog2(NREGS).
  - bits[A-1:0] = address.
- Address NREGS-1 is the status register:
  - a read returns err_cnt;
  - a write of any data clears err_cnt and does not change regs_flat.
- FSM states: IDLE, GET_DATA, GET_CSUM. All transitions occur on a tck rising edge with rx_valid=1, unless stated otherwise.
  - IDLE, header has nonzero reserved bits: err_cnt++ (saturating at ERR_SAT); stay IDLE.
  - IDLE, read header: on the next edge, tx_byte = reg[addr] (or err_cnt for the status address) and tx_valid pulses for 1 cycle; stay IDLE.
  - IDLE, write header: latch addr; go to GET_DATA.
  - GET_DATA: latch data; go to GET_CSUM.
  - GET_CSUM:
    - If byte == header XOR data: commit; go to IDLE.
    - Else: err_cnt++ (saturating); no commit; go to IDLE.
- Commit timing:
  - register updates on the edge that samples the checksum byte;
  - wr_strobe = 1 and wr_addr = addr during the following cycle.
- rx_valid=0 holds the FSM state. There is no timeout, because TCK is free-running only during JTAG activity.
- abort=1 forces IDLE on the next edge.
  - abort together with rx_valid: abort wins; the byte is dropped; err_cnt is unchanged.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss.
- err_cnt saturates at ERR_SAT and never wraps.
- An increment and a status-write clear in the same cycle cannot occur.
- tx_byte holds its value between reads. tx_valid and wr_strobe are registered single-cycle pulses.

Decomposition:
- Shared package vjtag_bridge_pkg holds:
  - state enum: IDLE, GET_DATA, GET_CSUM;
  - OP_WRITE = 1'b1, OP_READ = 1'b0;
  - header bit positions;
  - function addr_w(NREGS).
- One sub-module, vjtag_reg_bank: NREGS x 8 register file with a write port, a combinational read mux and a flattened output.
- The frame FSM, checksum and error counter stay in the top.

Test Plan:
- Reset: assert aclr mid-frame (after header 8'h81) -> all outputs 0, regs_flat = 0; the next frame 8'h82,8'h3C,8'hBE then writes reg2 = 8'h3C.
- Write and readback: frame 8'h80,8'hA5,8'h25, then read 8'h00 -> wr_strobe pulse with wr_addr = 0, LED bits regs_flat[7:0] = 8'hA5; tx_byte = 8'hA5 with a 1-cycle tx_valid.
- Bad checksum: 8'h83,8'h11,8'h00 -> reg3 unchanged, err_cnt = 1.
- Reserved bits: header 8'h48 -> err_cnt = 1; read 8'h07 -> tx_byte = 8'h01; write 8'h87,8'h00,8'h87 -> err_cnt = 0, regs_flat unchanged.
- Abort: 8'h81, then abort pulse, then 8'h81,8'h5A,8'hDB -> reg1 = 8'h5A, err_cnt = 0. A separate case with abort and rx_valid together drops that byte.
- Saturation and throughput: 300 bad headers back-to-back with rx_valid held every cycle -> err_cnt = 8'hFF, busy stays 0.
